// File: rtl/vga_cell_buffer.sv
// Cell-based colour source for the VGA timing stage: 80x60 cells of 3-bit colour,
// a valid/ready cell write port and a full-frame clear engine.
module vga_cell_buffer #(
    parameter int unsigned CELL_SHIFT = 3,
    parameter int unsigned COLS       = 80,
    parameter int unsigned ROWS       = 60
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [10:0] hcount_i,
    input  logic [10:0] vcount_i,
    output logic [7:0]  color_o,
    input  logic        wr_valid_i,
    output logic        wr_ready_o,
    input  logic [6:0]  wr_col_i,
    input  logic [5:0]  wr_row_i,
    input  logic [2:0]  wr_color_i,
    output logic        wr_err_o,
    input  logic        clr_req_i,
    input  logic [2:0]  clr_color_i,
    output logic        busy_o,
    output logic        clr_done_o
);

    localparam int unsigned Cells = COLS * ROWS;
    localparam int unsigned AW    = $clog2(Cells);

    localparam logic [AW-1:0] LastAddr = AW'(Cells - 1);
    localparam logic [AW-1:0] ColsA    = AW'(COLS);
    localparam logic [10:0]   ColsPix  = 11'(COLS);
    localparam logic [10:0]   RowsPix  = 11'(ROWS);
    localparam logic [6:0]    ColsWr   = 7'(COLS);
    localparam logic [5:0]    RowsWr   = 6'(ROWS);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StClear = 1'b1;

    // ------------------------------------------------------------------
    // Read pipeline: S1 address generation, S2 memory read, S3 decode
    // ------------------------------------------------------------------
    logic [10:0]   col_d;
    logic [10:0]   row_d;
    logic          vis_d;
    logic [AW-1:0] addr_d;

    logic          vis_q;
    logic [AW-1:0] addr_q;
    logic          vis_rd_q;
    logic [2:0]    rd_data_q;

    always_comb begin
        col_d  = hcount_i >> CELL_SHIFT;
        row_d  = vcount_i >> CELL_SHIFT;
        vis_d  = (col_d < ColsPix) && (row_d < RowsPix);
        // Blank positions read address 0 so the memory is never indexed past its end.
        addr_d = vis_d ? (AW'(row_d) * ColsA + AW'(col_d)) : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vis_q    <= 1'b0;
            addr_q   <= '0;
            vis_rd_q <= 1'b0;
        end else begin
            vis_q    <= vis_d;
            addr_q   <= addr_d;
            vis_rd_q <= vis_q;
        end
    end

    always_comb begin
        color_o = 8'h01;
        if (vis_rd_q) begin
            color_o = 8'h01 << rd_data_q;
        end
    end

    // ------------------------------------------------------------------
    // Cell memory: one write port, one read port, read-first
    // ------------------------------------------------------------------
    logic [2:0]    mem [Cells];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [2:0]    mem_wdata;

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_q <= mem[addr_q];
    end

    // ------------------------------------------------------------------
    // Write port and clear engine
    // ------------------------------------------------------------------
    logic [0:0]    state_q,     state_d;
    logic [AW-1:0] clr_ptr_q,   clr_ptr_d;
    logic [2:0]    clr_color_q, clr_color_d;
    logic          wr_err_q,    wr_err_d;
    logic          clr_done_q,  clr_done_d;

    logic          wr_in_range;
    logic [AW-1:0] wr_addr;

    assign wr_in_range = (wr_col_i < ColsWr) && (wr_row_i < RowsWr);
    assign wr_addr     = AW'(wr_row_i) * ColsA + AW'(wr_col_i);

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        clr_color_d = clr_color_q;
        wr_err_d    = 1'b0;
        clr_done_d  = 1'b0;
        mem_we      = 1'b0;
        mem_waddr   = wr_addr;
        mem_wdata   = wr_color_i;
        wr_ready_o  = 1'b0;
        busy_o      = (state_q == StClear);

        case (state_q)
            StIdle: begin
                wr_ready_o = ~clr_req_i;
                if (clr_req_i) begin
                    // A clear request wins over a simultaneous write.
                    clr_color_d = clr_color_i;
                    clr_ptr_d   = '0;
                    state_d     = StClear;
                end else if (wr_valid_i) begin
                    if (wr_in_range) begin
                        mem_we = 1'b1;
                    end else begin
                        wr_err_d = 1'b1;
                    end
                end
            end
            StClear: begin
                mem_we    = 1'b1;
                mem_waddr = clr_ptr_q;
                mem_wdata = clr_color_q;
                if (clr_ptr_q == LastAddr) begin
                    clr_ptr_d  = '0;
                    clr_done_d = 1'b1;
                    state_d    = StIdle;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            clr_ptr_q   <= '0;
            clr_color_q <= 3'd0;
            wr_err_q    <= 1'b0;
            clr_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            clr_color_q <= clr_color_d;
            wr_err_q    <= wr_err_d;
            clr_done_q  <= clr_done_d;
        end
    end

    assign wr_err_o   = wr_err_q;
    assign clr_done_o = clr_done_q;

endmodule
